// File: rtl/ultrasonic_dist_proc_pkg.sv
// Shared constants and FSM encoding for the ultrasonic distance post-processor.
package ultrasonic_dist_proc_pkg;

    localparam int DIST_W     = 9;
    localparam int CONV_ITERS = 9;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ACCUM   = ST_ACCUM,
        CONVERT = ST_CONVERT,
        DONE    = ST_DONE
    } state_t;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/ultrasonic_dist_proc_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock.
module bin2bcd_seq
    import ultrasonic_dist_proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset_p,
    input  logic              start,
    input  logic [DIST_W-1:0] bin,
    output logic              done,
    output logic [3:0]        hund,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    localparam int SH_W = DIST_W + 12;

    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] adj;
    logic [3:0]      cnt;
    logic            running;

    always_comb begin
        adj = shreg;
        adj[SH_W-1:SH_W-4]   = dabble(shreg[SH_W-1:SH_W-4]);
        adj[SH_W-5:SH_W-8]   = dabble(shreg[SH_W-5:SH_W-8]);
        adj[SH_W-9:SH_W-12]  = dabble(shreg[SH_W-9:SH_W-12]);
    end

    // done marks the cycle whose closing edge performs the final iteration
    assign done = running && (cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            shreg   <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            shreg   <= {12'b0, bin};
            cnt     <= 4'(CONV_ITERS);
            running <= 1'b1;
        end else if (running) begin
            shreg <= {adj[SH_W-2:0], 1'b0};
            cnt   <= cnt - 4'd1;
            if (cnt == 4'd1)
                running <= 1'b0;
        end
    end

    assign hund = shreg[SH_W-1:SH_W-4];
    assign tens = shreg[SH_W-5:SH_W-8];
    assign ones = shreg[SH_W-9:SH_W-12];

endmodule

// File: rtl/ultrasonic_dist_proc.sv
// Range check, power-of-two moving average and BCD conversion of distances.
module ultrasonic_dist_proc
    import ultrasonic_dist_proc_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int MIN_CM   = 2,
    parameter int MAX_CM   = 400
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [8:0] dis_time,
    input  logic       dis_valid,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       out_valid,
    output logic       out_of_range,
    output logic       busy,
    output logic       dropped
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = DIST_W + AVG_LOG2;
    localparam logic [DIST_W-1:0] MIN_V = DIST_W'(MIN_CM);
    localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_CM);

    state_t              state;
    logic [DIST_W-1:0]   sample;
    logic [DIST_W-1:0]   win [N];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic                filled;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;
    logic [DIST_W-1:0]   avg;
    logic                in_range;
    logic                conv_start;
    logic                conv_done;
    logic [3:0]          conv_hund;
    logic [3:0]          conv_tens;
    logic [3:0]          conv_ones;

    assign in_range = (dis_time >= MIN_V) && (dis_time <= MAX_V);

    // An empty window is preloaded with N copies of the first sample
    always_comb begin
        sum_next = sum;
        if (!filled)
            sum_next = SUM_W'(sample) << AVG_LOG2;
        else
            sum_next = sum - SUM_W'(win[wr_ptr]) + SUM_W'(sample);
    end

    assign avg        = sum_next[SUM_W-1:AVG_LOG2];
    assign conv_start = (state == ACCUM);

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (conv_start),
        .bin     (avg),
        .done    (conv_done),
        .hund    (conv_hund),
        .tens    (conv_tens),
        .ones    (conv_ones)
    );

    always_ff @(posedge clk) begin
        if (state == ACCUM) begin
            if (!filled) begin
                for (int i = 0; i < N; i++)
                    win[i] <= sample;
            end else begin
                win[wr_ptr] <= sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state        <= IDLE;
            sample       <= '0;
            wr_ptr       <= '0;
            filled       <= 1'b0;
            sum          <= '0;
            bcd_hund     <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
            out_valid    <= 1'b0;
            out_of_range <= 1'b0;
            busy         <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            dropped   <= dis_valid && (state != IDLE);
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (dis_valid) begin
                        if (in_range) begin
                            sample       <= dis_time;
                            out_of_range <= 1'b0;
                            busy         <= 1'b1;
                            state        <= ACCUM;
                        end else begin
                            out_of_range <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    sum    <= sum_next;
                    filled <= 1'b1;
                    if (filled)
                        wr_ptr <= wr_ptr + 1'b1;
                    state <= CONVERT;
                end
                CONVERT: begin
                    if (conv_done)
                        state <= DONE;
                end
                DONE: begin
                    bcd_hund  <= conv_hund;
                    bcd_tens  <= conv_tens;
                    bcd_ones  <= conv_ones;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ultrasonic_dist_proc.md
# ultrasonic_dist_proc

Post-processing stage for the HC-SR04 ranging path. It consumes each 9-bit centimetre distance the ultrasonic controller produces and rejects samples outside the valid range. Accepted samples feed a power-of-two moving average, and the block converts the averaged value to three BCD digits with a sequential double-dabble. The BCD digits feed the FND display driver directly.

## Interface
- `AVG_LOG2`, default 2: log2 of the averaging window (N = 4 entries); legal range 1..3.
- `MIN_CM`, default 2: smallest accepted distance, in cm.
- `MAX_CM`, default 400: largest accepted distance, in cm.
- `clk` input, 1 bit: system clock. One clock domain only.
- `reset_p` input, 1 bit: reset. Synchronous and active-high.
- `dis_time` input, 9 bits: distance sample, in cm.
- `dis_valid` input, 1 bit: one-cycle strobe. `dis_time` is valid while it is high.
- `bcd_hund`, `bcd_tens`, `bcd_ones` output, 4 bits each: averaged distance in BCD.
- `out_valid` output, 1 bit: one-cycle pulse when new digits appear.
- `out_of_range` output, 1 bit: level. Set when the last offered sample was rejected.
- `busy` output, 1 bit: high while a sample is being processed.
- `dropped` output, 1 bit: one-cycle pulse when `dis_valid` arrives while `busy`.

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE, the buffer is marked empty, and sum = 0.
- **FSM states:** IDLE, ACCUM, CONVERT, DONE.
- **IDLE with `dis_valid`=1 and `dis_time` out of range** (below `MIN_CM` or above `MAX_CM`):
  - set `out_of_range`=1 and discard the sample;
  - stay in IDLE, with no `out_valid` and the digits unchanged;
  - the discarded sample does not fill an empty buffer.
- **IDLE with `dis_valid`=1 and `dis_time` in range:** latch the sample, clear `out_of_range`, and go to ACCUM.
- **ACCUM, buffer empty:** write the sample into all N entries and set sum = N × sample.
- **ACCUM, buffer not empty:**
  - sum = sum − buf[wr_ptr] + sample;
  - buf[wr_ptr] = sample;
  - wr_ptr increments modulo N.
- **Leaving ACCUM:** load avg = sum_next >> `AVG_LOG2` (truncating) into the converter, then go to CONVERT.
- **CONVERT:** 9 double-dabble iterations at one per cycle. Each iteration adds 3 to any BCD nibble ≥ 5, then shifts left by 1. After the 9th iteration, go to DONE.
- **DONE:** register the digits, pulse `out_valid` for one cycle, and return to IDLE.
- **Arithmetic widths:**
  - sum is 9 + `AVG_LOG2` bits and never overflows;
  - avg is 9 bits and is at most `MAX_CM`;
  - the hundreds digit is at most 5.
- **`dis_valid` outside IDLE:** the sample is ignored and `dropped` pulses one cycle later. State, sum and digits are unaffected.
- **`reset_p` mid-operation:** abort to IDLE with all outputs cleared. The buffer returns to empty, so the next accepted sample refills it.

## Timing
- Let E0 be the edge that samples `dis_valid`=1 in IDLE (in range).
- E1: enter CONVERT with avg loaded.
- E2 through E10: the 9 conversion iterations; E10 enters DONE.
- E11: digits update and `out_valid` rises. It is high for the cycle after E11.
- Latency from the sampling edge to `out_valid` is 11 clocks.
- `busy` is high from E0 through E11, then low again with the return to IDLE.
- A new sample can be accepted at E12 at the earliest, so the minimum spacing between samples is 12 clocks. Upstream spacing is ≥ 60 ms, far above this.
- `out_of_range` updates at E0 for both accepted and rejected samples.
- The digits hold their value between `out_valid` pulses.

## Structure
- **Shared package:** FSM state encoding (2-bit localparams), the 9-bit distance width constant, and the iteration count of 9.
- **Sub-module `bin2bcd_seq`:** start/done handshake; 9-bit binary in, three BCD nibbles out; 9 cycles per conversion.
- **Top level:** the range check, circular buffer, running sum and FSM.

## Test plan
- Reset, then sample 100 → `out_valid` 11 clocks later with digits 1/0/0; `busy` high for 12 cycles.
- After 100, send 104 → avg = (300+104)>>2 = 101, giving 1/0/1. Send three more 104s → the final output is 1/0/4.
- Send 450, then 1 → `out_of_range`=1 both times, no `out_valid`, digits stay 1/0/4. Then send 50 → `out_of_range` clears.
- Send 200, then `dis_valid` again 3 clocks later → `dropped` pulses once and only one `out_valid` occurs.
- Assert `reset_p` at E5 of a conversion → outputs are 0 on the next cycle. Then send 37 → buffer preloads and output is 0/3/7.
- Send 400 four times with the window full → 4/0/0. Send 399 → sum 1599, avg 399, giving 3/9/9.
